param_updown_counter: RTL and testbench

Parametrised synchronous counter; next generation of the team's fixed 4-bit up-counter. Adds configurable width and modulus, up/down/bounce/hold modes, wrap or saturate behaviour, synchronous load and a registered terminal-count pulse. Intended as the general-purpose counting element for timers, address generators and divided strobes in the design.

---
 rtl/param_updown_counter.sv | 114 +++++++++++
 tb/tb_param_updown_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down/bounce counter with wrap or saturate limits, synchronous
// load and a registered terminal-count pulse coincident with the post-event count.
module param_updown_counter #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    mode_e            mode_q;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_nxt;
    logic             tc_nxt;

    assign mode_q    = mode_e'(mode);
    assign count_inc = count + ONE;
    assign count_dec = count - ONE;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        count_nxt = count;
        dir_nxt   = dir;
        tc_nxt    = 1'b0;

        if (load) begin
            count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en && mode_q != MODE_HOLD) begin
            unique case (mode_q)
                MODE_UP: begin
                    dir_nxt = 1'b0;
                    if (count == MAX_C) begin
                        if (!sat) begin
                            count_nxt = '0;
                            tc_nxt    = 1'b1;
                        end
                    end else begin
                        count_nxt = count_inc;
                        tc_nxt    = sat && (count_inc == MAX_C);
                    end
                end
                MODE_DOWN: begin
                    dir_nxt = 1'b1;
                    if (count == '0) begin
                        if (!sat) begin
                            count_nxt = MAX_C;
                            tc_nxt    = 1'b1;
                        end
                    end else begin
                        count_nxt = count_dec;
                        tc_nxt    = sat && (count_dec == '0);
                    end
                end
                MODE_BOUNCE: begin
                    // Turning around at either end steps away immediately, so the end value is never repeated.
                    if (!dir) begin
                        if (count == MAX_C) begin
                            dir_nxt   = 1'b1;
                            count_nxt = MAX_C - ONE;
                            tc_nxt    = 1'b1;
                        end else begin
                            count_nxt = count_inc;
                        end
                    end else begin
                        if (count == '0) begin
                            dir_nxt   = 1'b0;
                            count_nxt = ONE;
                            tc_nxt    = 1'b1;
                        end else begin
                            count_nxt = count_dec;
                        end
                    end
                end
                default: begin
                    count_nxt = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
            dir   <= 1'b0;
            tc    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all three registers update from the same pre-edge state.
            count <= count_nxt;
            dir   <= dir_nxt;
            tc    <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter with WIDTH=4, MAX_VAL=9; expected
// values are hand-derived sequences sampled 1 time unit after each rising edge.
module tb_param_updown_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [1:0] mode;
    logic       sat;
    logic [3:0] count;
    logic       dir;
    logic       tc;

    int total = 0;
    int bad   = 0;

    // Bounce sweep starting from count=0, dir=1 with MAX_VAL=9.
    int bseq_cnt[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .sat      (sat),
        .count    (count),
        .dir      (dir),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic expect_state(input string tag, input int c, input bit d, input bit t);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".dir"},   32'(dir),   32'(d));
        check({tag, ".tc"},    32'(tc),    32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr      = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        mode     = 2'b00;
        sat      = 1'b0;

        tick();
        tick();
        expect_state("reset", 0, 1'b0, 1'b0);
        clr = 1'b1;

        // Up, wrap: 1..9,0,1,2 with tc on the wrap to 0.
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            expect_state($sformatf("up_wrap[%0d]", i), i % 10, 1'b0, (i % 10) == 0);
        end

        // Up, saturate: climbs to 9, pulses once, then holds.
        load = 1'b1; load_val = 4'd0; sat = 1'b1;
        tick();
        expect_state("load0", 0, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            expect_state($sformatf("up_sat[%0d]", i), (i > 9) ? 9 : i, 1'b0, i == 9);
        end

        // Down, wrap: load 3 then 2,1,0,9,8 with tc on the wrap to 9.
        sat = 1'b0; mode = 2'b01; load = 1'b1; load_val = 4'd3;
        tick();
        expect_state("load3", 3, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_state($sformatf("down_wrap[%0d]", i), (13 - i) % 10, 1'b1, i == 4);
        end

        // Out-of-range load clamps to MAX_VAL.
        load = 1'b1; load_val = 4'd14;
        tick();
        expect_state("load_clamp", 9, 1'b1, 1'b0);

        // Down, saturate: 8..0 with a single tc on reaching 0, then hold.
        load = 1'b0; sat = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            expect_state($sformatf("down_sat[%0d]", i), (i > 9) ? 0 : 9 - i, 1'b1, i == 9);
        end

        // Bounce from count=0, dir=1; en drops for two cycles mid-sweep.
        sat = 1'b0; mode = 2'b10;
        for (int i = 0; i < 20; i++) begin
            if (i == 14) begin
                en = 1'b0;
                tick();
                expect_state("bounce_hold0", 4, 1'b1, 1'b0);
                tick();
                expect_state("bounce_hold1", 4, 1'b1, 1'b0);
                en = 1'b1;
            end
            tick();
            expect_state($sformatf("bounce[%0d]", i), bseq_cnt[i],
                         (i >= 9 && i <= 17), (i == 0 || i == 9 || i == 18));
        end

        // Load beats the wrap condition at count=9; mode 11 holds with en=1.
        mode = 2'b00; load = 1'b1; load_val = 4'd9;
        tick();
        expect_state("load9", 9, 1'b0, 1'b0);
        load_val = 4'd5;
        tick();
        expect_state("load_vs_wrap", 5, 1'b0, 1'b0);
        load = 1'b0; mode = 2'b11;
        tick();
        expect_state("mode_hold0", 5, 1'b0, 1'b0);
        tick();
        expect_state("mode_hold1", 5, 1'b0, 1'b0);

        // Asynchronous clear mid-cycle while count=6, dir=1.
        mode = 2'b00; load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0; mode = 2'b01;
        tick();
        expect_state("pre_clr", 6, 1'b1, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        expect_state("async_clr", 0, 1'b0, 1'b0);
        #1;
        clr = 1'b1; mode = 2'b00;
        tick();
        expect_state("resume", 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
